// File: rtl/ripple_ext_pkg.sv
// Shared definitions for the ripple counter extender.
// Holds the FSM state encoding, the default widths and the width of the
// stability hold counter.
package ripple_ext_pkg;

    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned EXT_W_DEF = 16;

    // Hold counter width; fits STABLE_CYCLES values up to 15.
    localparam int unsigned HOLD_W = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/count_stable_filter.sv
// Synchronizes the asynchronous ripple count into the clk domain and accepts
// a value only after it has been seen unchanged for STABLE_CYCLES cycles.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   cnt_in     - ripple counter output, asynchronous to clk
//   acc_valid  - one-cycle pulse when a stable value is accepted
//   acc_value  - the accepted value, held until the next acceptance
module count_stable_filter
    import ripple_ext_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             acc_valid,
    output logic [CNT_W-1:0] acc_value
);

    localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(STABLE_CYCLES);

    logic [CNT_W-1:0]  sync1;
    logic [CNT_W-1:0]  sync2;
    logic [HOLD_W-1:0] hold;
    logic              changed_c;
    logic [HOLD_W-1:0] hold_next_c;
    logic              accept_c;

    // sync2 is about to take a new value when the two stages differ.
    // hold counts cycles sync2 has held its value and saturates at the target,
    // so a value is accepted exactly once however long it is held.
    always_comb begin
        changed_c   = (sync1 != sync2);
        hold_next_c = hold;
        if (changed_c) begin
            hold_next_c = HOLD_W'(1);
        end else if (hold != HOLD_TARGET) begin
            hold_next_c = hold + 1'b1;
        end
        accept_c = (hold_next_c == HOLD_TARGET) && (changed_c || (hold != HOLD_TARGET));
    end

    // Two-flop synchronizer, hold counter and registered acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            hold      <= '0;
            acc_valid <= 1'b0;
            acc_value <= '0;
        end else begin
            sync1     <= cnt_in;
            sync2     <= sync1;
            hold      <= hold_next_c;
            acc_valid <= accept_c;
            if (accept_c) begin
                acc_value <= sync1;
            end
        end
    end

endmodule

// File: rtl/ripple_count_extender.sv
// Extends a narrow asynchronous ripple count into a wide synchronous count.
// Accepted values are turned into modular steps and accumulated.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   cnt_in      - ripple counter output, asynchronous to clk
//   clr         - clears ext_count, overflow and delta
//   ext_count   - accumulated count
//   ext_valid   - set once the first stable value is accepted
//   delta       - step applied on the most recent update
//   wrap_pulse  - one-cycle pulse when a step crossed the low counter wrap
//   overflow    - sticky, set when ext_count wraps
module ripple_count_extender
    import ripple_ext_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned EXT_W         = EXT_W_DEF,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clr,
    output logic [EXT_W-1:0] ext_count,
    output logic             ext_valid,
    output logic [CNT_W-1:0] delta,
    output logic             wrap_pulse,
    output logic             overflow
);

    localparam int unsigned SUM_W = EXT_W + 1;

    state_t           state;
    state_t           state_next;
    logic             acc_valid;
    logic [CNT_W-1:0] acc_value;
    logic [CNT_W-1:0] prev;

    logic [CNT_W-1:0] step_c;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] prev_next;
    logic [EXT_W-1:0] ext_count_next;
    logic [CNT_W-1:0] delta_next;
    logic             wrap_next;
    logic             overflow_next;
    logic             ext_valid_next;

    count_stable_filter #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .acc_valid (acc_valid),
        .acc_value (acc_value)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the first acceptance establishes the baseline.
    always_comb begin
        state_next = state;
        if ((state == INIT) && acc_valid) begin
            state_next = RUN;
        end
    end

    // Output logic: modular step, accumulation and flags.
    always_comb begin
        step_c         = acc_value - prev;
        sum_c          = SUM_W'(ext_count) + SUM_W'(step_c);
        prev_next      = prev;
        ext_count_next = ext_count;
        delta_next     = delta;
        wrap_next      = 1'b0;
        overflow_next  = overflow;
        ext_valid_next = ext_valid;

        if (acc_valid) begin
            case (state)
                INIT: begin
                    prev_next      = acc_value;
                    ext_valid_next = 1'b1;
                end
                RUN: begin
                    if (acc_value != prev) begin
                        prev_next      = acc_value;
                        ext_count_next = sum_c[EXT_W-1:0];
                        delta_next     = step_c;
                        wrap_next      = (acc_value < prev);
                        overflow_next  = overflow | sum_c[EXT_W];
                    end
                end
                default: ;
            endcase
        end

        // A coincident step is discarded, but prev still follows the input.
        if (clr) begin
            ext_count_next = '0;
            delta_next     = '0;
            wrap_next      = 1'b0;
            overflow_next  = 1'b0;
        end
    end

    // Output and baseline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            ext_count  <= '0;
            delta      <= '0;
            wrap_pulse <= 1'b0;
            overflow   <= 1'b0;
            ext_valid  <= 1'b0;
        end else begin
            prev       <= prev_next;
            ext_count  <= ext_count_next;
            delta      <= delta_next;
            wrap_pulse <= wrap_next;
            overflow   <= overflow_next;
            ext_valid  <= ext_valid_next;
        end
    end

endmodule

// File: tb/tb_ripple_count_extender.sv
// Directed bench for ripple_count_extender: a 16-bit instance for the main
// function and a 5-bit instance for overflow, checked against a scoreboard.
module tb_ripple_count_extender;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, clr_a, rst_b, clr_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [15:0] ext_a;
    logic [4:0]  ext_b;
    logic        valid_a, valid_b, wrap_a, wrap_b, ovf_a, ovf_b;
    logic [3:0]  delta_a, delta_b;

    ripple_count_extender #(.CNT_W(4), .EXT_W(16), .STABLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst_a), .cnt_in(cnt_a), .clr(clr_a),
        .ext_count(ext_a), .ext_valid(valid_a), .delta(delta_a),
        .wrap_pulse(wrap_a), .overflow(ovf_a)
    );

    ripple_count_extender #(.CNT_W(4), .EXT_W(5), .STABLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst_b), .cnt_in(cnt_b), .clr(clr_b),
        .ext_count(ext_b), .ext_valid(valid_b), .delta(delta_b),
        .wrap_pulse(wrap_b), .overflow(ovf_b)
    );

    typedef struct {
        logic [15:0] ext;
        logic [3:0]  delta;
        logic        wrap;
        logic        ovf;
        logic        valid;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [3:0] mprev;
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         sel    = 1'b0;
    int         ew     = 16;
    int         wraps_a = 0;
    int         wraps_b = 0;

    // Count sampled wrap pulses on each instance.
    always @(negedge clk) begin
        if (wrap_a === 1'b1) wraps_a++;
        if (wrap_b === 1'b1) wraps_b++;
    end

    task automatic chk(input string tag, input string f, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, o, e);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e);
        if (sel) begin
            chk(tag, "ext_count", 32'(ext_b), 32'(e.ext));
            chk(tag, "delta", 32'(delta_b), 32'(e.delta));
            chk(tag, "wrap_pulse", 32'(wrap_b), 32'(e.wrap));
            chk(tag, "overflow", 32'(ovf_b), 32'(e.ovf));
            chk(tag, "ext_valid", 32'(valid_b), 32'(e.valid));
        end else begin
            chk(tag, "ext_count", 32'(ext_a), 32'(e.ext));
            chk(tag, "delta", 32'(delta_a), 32'(e.delta));
            chk(tag, "wrap_pulse", 32'(wrap_a), 32'(e.wrap));
            chk(tag, "overflow", 32'(ovf_a), 32'(e.ovf));
            chk(tag, "ext_valid", 32'(valid_a), 32'(e.valid));
        end
    endtask

    task automatic drive_cnt(input logic [3:0] v);
        if (sel) cnt_b = v; else cnt_a = v;
    endtask

    task automatic drive_clr(input logic v);
        if (sel) clr_b = v; else clr_a = v;
    endtask

    task automatic drive_rst(input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // Bench model of one accepted value; returns whether outputs change.
    task automatic model_accept(input logic [3:0] v, input bit with_clr, output bit upd);
        logic [3:0]  d;
        int unsigned s;
        upd      = 1'b0;
        cur.wrap = 1'b0;
        if (!cur.valid) begin
            cur.valid = 1'b1;
            mprev     = v;
            upd       = 1'b1;
        end else if (v != mprev) begin
            d         = v - mprev;
            s         = int'(cur.ext) + int'(d);
            cur.wrap  = (v < mprev);
            cur.ovf   = cur.ovf | ((s >> ew) != 0);
            cur.ext   = 16'(s & ((1 << ew) - 1));
            cur.delta = d;
            mprev     = v;
            upd       = 1'b1;
        end
        if (with_clr) begin
            cur.ext   = '0;
            cur.ovf   = 1'b0;
            cur.delta = '0;
            cur.wrap  = 1'b0;
            upd       = 1'b1;
        end
        sb.push_back(cur);
    endtask

    task automatic do_reset(input string tag, input int cycles);
        @(negedge clk);
        drive_rst(1'b1);
        cur   = '{ext: 16'h0, delta: 4'h0, wrap: 1'b0, ovf: 1'b0, valid: 1'b0};
        mprev = '0;
        sb.push_back(cur);
        repeat (cycles) @(posedge clk);
        #1;
        cmp(tag, sb.pop_front());
    endtask

    // Drive a value, confirm nothing changes one edge early, then check it lands.
    task automatic apply(input string tag, input logic [3:0] v, input int hold, input bit release_rst);
        exp_t old;
        bit   upd;
        @(negedge clk);
        if (release_rst) drive_rst(1'b0);
        drive_cnt(v);
        old = cur;
        model_accept(v, 1'b0, upd);
        repeat (3) @(posedge clk);
        #1;
        if (upd) begin
            if (sel) begin
                chk({tag, "_early"}, "ext_count", 32'(ext_b), 32'(old.ext));
                chk({tag, "_early"}, "ext_valid", 32'(valid_b), 32'(old.valid));
            end else begin
                chk({tag, "_early"}, "ext_count", 32'(ext_a), 32'(old.ext));
                chk({tag, "_early"}, "ext_valid", 32'(valid_a), 32'(old.valid));
            end
        end
        @(posedge clk);
        #1;
        cmp(tag, sb.pop_front());
        repeat (hold) @(posedge clk);
    endtask

    // One-cycle excursion to g before settling on v; only v may be counted.
    task automatic glitch(input string tag, input logic [3:0] g, input logic [3:0] v);
        exp_t old;
        bit   upd;
        @(negedge clk);
        drive_cnt(g);
        @(negedge clk);
        drive_cnt(v);
        old = cur;
        model_accept(v, 1'b0, upd);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_early"}, "ext_count", 32'(ext_a), 32'(old.ext));
        chk({tag, "_early"}, "delta", 32'(delta_a), 32'(old.delta));
        @(posedge clk);
        #1;
        cmp(tag, sb.pop_front());
    endtask

    // clr asserted exactly on the edge where the update for v lands.
    task automatic collide(input string tag, input logic [3:0] v);
        bit upd;
        @(negedge clk);
        drive_cnt(v);
        model_accept(v, 1'b1, upd);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive_clr(1'b1);
        @(posedge clk);
        #1;
        drive_clr(1'b0);
        cmp(tag, sb.pop_front());
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        drive_clr(1'b1);
        cur.ext   = '0;
        cur.ovf   = 1'b0;
        cur.delta = '0;
        cur.wrap  = 1'b0;
        sb.push_back(cur);
        @(posedge clk);
        #1;
        drive_clr(1'b0);
        cmp(tag, sb.pop_front());
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        cnt_a = 4'd0; cnt_b = 4'd0;

        // Main instance: baseline, increments, low wrap, glitch, hold, collision.
        sel = 1'b0;
        ew  = 16;
        do_reset("reset_a", 3);
        apply("baseline5", 4'd5, 0, 1'b1);
        apply("inc6", 4'd6, 0, 1'b0);
        apply("inc7", 4'd7, 0, 1'b0);
        apply("inc8", 4'd8, 0, 1'b0);
        apply("to14", 4'd14, 0, 1'b0);
        apply("wrap15", 4'd15, 0, 1'b0);
        apply("wrap0", 4'd0, 0, 1'b0);
        apply("wrap1", 4'd1, 0, 1'b0);
        apply("jump7", 4'd7, 0, 1'b0);
        glitch("glitch6_8", 4'd6, 4'd8);
        apply("hold8", 4'd8, 8, 1'b0);
        collide("collide9", 4'd9);
        apply("after_clr11", 4'd11, 0, 1'b0);
        do_reset("reset_mid", 2);
        apply("rebase3", 4'd3, 0, 1'b1);
        apply("rebase_inc4", 4'd4, 0, 1'b0);
        chk("wrap_count_a", "pulses", 32'(wraps_a), 32'd1);

        // Narrow instance: 33 unit steps wrap the 5-bit accumulator.
        sel = 1'b1;
        ew  = 5;
        do_reset("reset_b", 3);
        apply("baseline_b", 4'd1, 0, 1'b1);
        for (int i = 1; i <= 33; i++) begin
            apply($sformatf("ovf_step%0d", i), 4'((1 + i) % 16), 0, 1'b0);
        end
        clr_pulse("clr_b");
        chk("wrap_count_b", "pulses", 32'(wraps_b), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_count_extender.md
# ripple_count_extender

- Synchronous consumer placed directly downstream of the 4-bit asynchronous ripple up-counter.
- Samples the counter's asynchronous multi-bit output into the `clk` domain and filters out ripple transients by requiring the sample to hold steady.
- Converts each accepted step into a modular delta and accumulates it into a wide extended count.
- Flags low-counter wrap-around and extended-count overflow.

## Interface
Parameters:
- `CNT_W`, 4, width of the incoming ripple count.
- `EXT_W`, 16, width of the extended accumulated count; must be greater than `CNT_W`.
- `STABLE_CYCLES`, 2, consecutive equal synchronized samples required to accept a value; range 1..15.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  synchronous, active-high reset; overrides all other inputs.
- `cnt_in`  in  `CNT_W`  ripple counter output; asynchronous to `clk`.
- `clr`  in  1  synchronous clear of the accumulator and overflow flag.
- `ext_count`  out  `EXT_W`  accumulated count.
- `ext_valid`  out  1  high once the first stable value has been accepted.
- `delta`  out  `CNT_W`  step applied on the most recent update.
- `wrap_pulse`  out  1  one-cycle pulse when an accepted step crossed the low counter's wrap point.
- `overflow`  out  1  sticky; set when `ext_count` wraps.

## Operation
**Synchronizer**
- Each bit of `cnt_in` passes through a two-flop synchronizer, `sync1` then `sync2`.

**Stability filter**
- A value of `sync2` is accepted only after it has remained equal for `STABLE_CYCLES` consecutive cycles.
- Any change in `sync2` restarts the hold count.
- A value is accepted once; holding it longer does not re-accept it.

**State machine**
- INIT:
  - On the first acceptance, load `prev` with the accepted value.
  - Set `ext_valid`; `ext_count` stays 0.
  - Go to RUN.
- RUN, on each acceptance with accepted value `new` different from `prev`:
  - `delta` = (`new` − `prev`) mod 2^`CNT_W`.
  - `ext_count` += `delta`, modulo 2^`EXT_W`.
  - `prev` = `new`.
  - `wrap_pulse` = 1 for one cycle if `new` < `prev` (old value).
  - `overflow` is set if the addition carries out of `EXT_W` bits.
- RUN, on acceptance of a value equal to `prev`: no update and no pulse.

**Correctness limit**
- Counts are correct only if the low counter advances fewer than 2^`CNT_W` steps between acceptances.
- Exceeding this limit aliases silently; detecting it is out of scope.

**`clr`**
- `ext_count` ← 0, `overflow` ← 0, `delta` ← 0.
- State, `prev` and `ext_valid` are kept.
- If `clr` and an update occur in the same cycle, `clr` wins and that step is discarded; `prev` still takes the new value.

**`rst`**
- Clears the synchronizer, filter, `prev`, all outputs and the state (to INIT), including when asserted mid-operation.
- After `rst` deasserts, the first accepted value is re-baselined and is not counted.

## Timing
- Reset values: `ext_count`=0, `ext_valid`=0, `delta`=0, `wrap_pulse`=0, `overflow`=0, state INIT.
- Latency: if `cnt_in` changes before edge k and then holds, `ext_count`, `delta`, `wrap_pulse` and `overflow` update on edge k+1+`STABLE_CYCLES`. With the default of 2, that is edge k+3.
- Back-to-back updates:
  - The minimum spacing between updates is `STABLE_CYCLES` cycles.
  - `wrap_pulse` is never high for two consecutive cycles when `STABLE_CYCLES` ≥ 2.
- `overflow` stays high until `clr` or `rst`.
- No input-to-output combinational paths; every output is registered.

## Structure
- Shared package `ripple_ext_pkg`:
  - State enum {INIT, RUN}.
  - Default width constants `CNT_W_DEF`=4 and `EXT_W_DEF`=16.
- Sub-module `count_stable_filter` contains the synchronizer plus the hold counter.
  - Parameters: `CNT_W`, `STABLE_CYCLES`.
  - Outputs: `acc_valid` (one-cycle pulse) and `acc_value`.
- Top level contains the FSM, the subtractor and the accumulator.

## Test plan
- **Reset baseline:** `rst` 3 cycles, then `cnt_in`=5 held → `ext_valid`=1 at edge 3 after the change; `ext_count`=0.
- **Increment:** from baseline 5, drive 6, 7, 8, each held 4 cycles → `ext_count`=3, final `delta`=1, `wrap_pulse` never asserted.
- **Low wrap:** from `prev`=14, drive 15, 0, 1 → `ext_count` +3; one `wrap_pulse` on the 15→0 update; 0→1 gives `delta`=1.
- **Ripple glitch:** `cnt_in`=7 → 6 for 1 cycle → 8 held → no update for the value 6; a single update with `delta`=1 from 7 to 8.
- **Overflow:** with `EXT_W`=5, apply 33 single steps → `ext_count`=1, `overflow`=1 sticky; a `clr` pulse then gives `ext_count`=0, `overflow`=0, `ext_valid`=1.
- **Collision:** assert `clr` in the same cycle an update lands → `ext_count`=0 and `prev` = new value; the next step of +2 gives `ext_count`=2.
